kernel_loader: RTL and testbench

KERNEL_LOADER -- requirements
Module: kernel_loader

---
 rtl/kernel_loader.sv | 99 +++++++++
 tb/tb_kernel_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_loader.sv
// Streams D-weight rows from a valid/ready source into a banked kernel buffer, one write per weight.
// Optional running checksum of the loaded weights: define KERNEL_LOADER_CHECKSUM_EN.
module kernel_loader #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [A-1:0]         baseAddr,
  input  logic [A:0]           rowCount,
  input  logic [W-1:0]         inData,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [A-1:0]         address,
  output logic [W+depth+1:0]   ioInputs,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         checksum
);
  localparam int D = 1 << depth;
  localparam int STAGES = 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  typedef struct packed {
    logic [A-1:0]     addr;
    logic [depth-1:0] bank;
    logic [W-1:0]     data;
  } wreq_t;

  logic [1:0]        state;
  logic [A-1:0]      row;
  logic [depth-1:0]  bank;
  logic [A:0]        rem;
  logic              sel;
  logic              wr_q;
  logic [STAGES:0]   vld_pipe;
  wreq_t             wreq;

  // stage 0 is the acceptance, stage 1 the buffer write it produces
  assign inReady  = (state == LOAD);
  assign vld_pipe = {wr_q, inValid & inReady};
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign address  = wreq.addr;
  assign ioInputs = {sel, vld_pipe[STAGES], wreq.bank, wreq.data};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      row   <= '0;
      bank  <= '0;
      rem   <= '0;
      sel   <= 1'b0;
      wr_q  <= 1'b0;
      wreq  <= '0;
    end else begin
      wr_q <= vld_pipe[0];
      // select stays up one cycle past LOAD so it covers the trailing write
      sel  <= (state == LOAD);
      if (vld_pipe[0]) wreq <= '{addr: row, bank: bank, data: inData};
      case (state)
        IDLE: if (start) begin
          row   <= baseAddr;
          rem   <= rowCount;
          bank  <= '0;
          state <= (rowCount == '0) ? FINISH : LOAD;
        end
        LOAD: if (vld_pipe[0]) begin
          bank <= bank + depth'(1);
          if (bank == depth'(D-1)) begin
            row <= row + A'(1);
            rem <= rem - (A+1)'(1);
            if (rem == (A+1)'(1)) state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KERNEL_LOADER_CHECKSUM_EN
  logic [W-1:0] cs;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        cs <= '0;
    else if (state == IDLE && start) cs <= '0;
    else if (vld_pipe[0])           cs <= cs + inData;
  end
  assign checksum = cs;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// Randomized and directed bench for kernel_loader against a weight-index based reference model.
module tb_kernel_loader;
  localparam int depth = 2, A = 7, W = 16, D = 1 << depth;

  logic CLK = 0, RST = 1, start = 0, inValid = 0;
  logic [A-1:0] baseAddr = '0;
  logic [A:0]   rowCount = '0;
  logic [W-1:0] inData = '0;
  logic inReady, busy, done;
  logic [A-1:0] address;
  logic [W+depth+1:0] ioInputs;
  logic [W-1:0] checksum;

  kernel_loader #(.depth(depth), .A(A), .W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .baseAddr(baseAddr), .rowCount(rowCount),
    .inData(inData), .inValid(inValid), .inReady(inReady), .address(address),
    .ioInputs(ioInputs), .busy(busy), .done(done), .checksum(checksum));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: weight k of a load goes to row base+k/D, bank k%D
  bit m_load, m_fin, m_wr, m_sel, m_acc;
  int m_k, m_tot, m_base, m_bank;
  logic [A-1:0] m_addr;
  logic [W-1:0] m_data, m_cs;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_load = 0; m_fin = 0; m_wr = 0; m_sel = 0; m_k = 0; m_tot = 0;
      m_base = 0; m_bank = 0; m_addr = '0; m_data = '0; m_cs = '0;
    end else begin
      m_acc = m_load && inValid;
      m_sel = m_load;
      m_wr  = m_acc;
      if (m_acc) begin
        m_addr = A'((m_base + m_k / D) % (1 << A));
        m_bank = m_k % D;
        m_data = inData;
        m_cs   = m_cs + inData;
        m_k++;
      end
      if (m_fin) m_fin = 0;
      else if (m_load) begin
        if (m_k == m_tot) begin m_load = 0; m_fin = 1; end
      end else if (start) begin
        m_base = int'(baseAddr); m_tot = int'(rowCount) * D; m_k = 0; m_cs = '0;
        if (m_tot == 0) m_fin = 1; else m_load = 1;
      end
    end
  end

  typedef struct { int addr; int bank; int data; bit dn; } wr_t;
  wr_t wlog[$];
  bit done_seen;
  logic [W-1:0] exp_cs;

  always @(negedge CLK) begin
    if (!RST) begin
`ifdef KERNEL_LOADER_CHECKSUM_EN
      exp_cs = m_cs;
`else
      exp_cs = '0;
`endif
      chk("inReady", inReady, m_load);
      chk("busy", busy, m_load | m_fin);
      chk("done", done, m_fin);
      chk("ioWrite", ioInputs[W+depth], m_wr);
      chk("ioSelect", ioInputs[W+depth+1], m_sel);
      chk("address", address, m_addr);
      chk("bank", ioInputs[W+depth-1:W], m_bank);
      chk("data", ioInputs[W-1:0], m_data);
      chk("checksum", checksum, exp_cs);
      if (done) done_seen = 1;
      if (ioInputs[W+depth])
        wlog.push_back('{int'(address), int'(ioInputs[W+depth-1:W]), int'(ioInputs[W-1:0]), done});
    end
  end

  task automatic do_start(input int b, input int r);
    @(negedge CLK); #1;
    start = 1; baseAddr = A'(b); rowCount = (A+1)'(r);
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic push(input logic [W-1:0] d);
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK); #1;
      if (inReady) begin
        inValid = 1; inData = d;
        @(posedge CLK); #1;
        inValid = 0;
        return;
      end
    end
    chk("push_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #3;
    chk("rst_address", address, 0);
    chk("rst_ioInputs", ioInputs, 0);
    chk("rst_inReady", inReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    #9 RST = 0;

    // 2 rows from row 5, weights 1..8 back to back
    wlog.delete();
    do_start(5, 2);
    for (int i = 1; i <= 8; i++) push(W'(i));
    wait_idle();
    chk("t2_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_addr", wlog[i].addr, 5 + i / 4);
        chk("t2_bank", wlog[i].bank, i % 4);
        chk("t2_data", wlog[i].data, i + 1);
      end
      chk("t2_done_last", wlog[7].dn, 1);
      chk("t2_done_early", wlog[6].dn, 0);
    end
`ifdef KERNEL_LOADER_CHECKSUM_EN
    chk("t2_checksum", checksum, 36);
`else
    chk("t2_checksum", checksum, 0);
`endif

    // empty load
    wlog.delete();
    do_start(9, 0);
    chk("t3_busy", busy, 1);
    chk("t3_done", done, 1);
    chk("t3_ready", inReady, 0);
    @(posedge CLK); #1;
    chk("t3_busy_after", busy, 0);
    chk("t3_done_after", done, 0);
    chk("t3_nowrite", wlog.size(), 0);

    // row pointer wrap
    wlog.delete();
    do_start(127, 2);
    for (int i = 0; i < 8; i++) push(W'($urandom));
    wait_idle();
    chk("t4_count", wlog.size(), 8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++) chk("t4_addr", wlog[i].addr, (i < 4) ? 127 : 0);

    // stalled stream: valid 1,0,0,1
    wlog.delete();
    do_start(10, 1);
    push(16'h00aa);
    repeat (2) @(posedge CLK);
    #1;
    chk("t5_stall_writes", wlog.size(), 1);
    push(16'h00bb);
    @(negedge CLK); #1;
    chk("t5_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t5_bank0", wlog[0].bank, 0);
      chk("t5_bank1", wlog[1].bank, 1);
      chk("t5_data1", wlog[1].data, 16'h00bb);
    end
    push(16'h1); push(16'h2);
    wait_idle();

    // reset after 3 accepted weights
    do_start(20, 2);
    push(16'h11); push(16'h22); push(16'h33);
    #2 RST = 1;
    #1;
    chk("t6_address", address, 0);
    chk("t6_ioInputs", ioInputs, 0);
    chk("t6_inReady", inReady, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_checksum", checksum, 0);
    @(negedge CLK); #2 RST = 0;
    done_seen = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("t6_no_done", done_seen, 0);
    wlog.delete();
    do_start(3, 1);
    for (int i = 0; i < 4; i++) push(W'(11 + i));
    wait_idle();
    chk("t6_count", wlog.size(), 4);
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t6_bank", wlog[i].bank, i);
        chk("t6_addr", wlog[i].addr, 3);
      end

    // start during LOAD is ignored
    wlog.delete();
    do_start(40, 2);
    push(16'h5); push(16'h6);
    @(negedge CLK); #1;
    start = 1; baseAddr = A'(99); rowCount = (A+1)'(1);
    @(posedge CLK); #1;
    start = 0;
    for (int i = 0; i < 6; i++) push(W'(i));
    wait_idle();
    chk("t7_count", wlog.size(), 8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++) chk("t7_addr", wlog[i].addr, 40 + i / 4);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK); #1;
      start    = ($urandom % 8) == 0;
      baseAddr = A'($urandom);
      rowCount = (A+1)'($urandom % 4);
      inValid  = $urandom % 2;
      inData   = W'($urandom);
    end
    @(negedge CLK); #1;
    start = 0; inValid = 1;
    wait_idle();
    inValid = 0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
